// File: rtl/nbit_pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// One lookahead block is resolved per pipeline stage; the whole pipe stalls together.
module nbit_pipelined_cla_adder #(
    parameter int BIT_NUMBER  = 64,
    parameter int BLOCK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_NUMBER-1:0] num_one,
    input  logic [BIT_NUMBER-1:0] num_two,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_NUMBER:0]   S,
    output logic                  overflow
);

    localparam int W  = BIT_NUMBER;
    localparam int BW = BLOCK_WIDTH;
    localparam int NB = W / BW;

    logic [W-1:0] a_q [NB];
    logic [W-1:0] b_q [NB];
    logic [W-1:0] s_q [NB];
    logic         c_q [NB];
    logic         v_q [NB];
    logic         ov_q;

    logic [W-1:0] a_d [NB];
    logic [W-1:0] b_d [NB];
    logic [W-1:0] s_d [NB];
    logic         c_d [NB];
    logic         v_d [NB];
    logic         ov_d;

    logic         en;

    // Global stall: the pipe advances unless a result is stuck at the output.
    always_comb begin
        en = !v_q[NB-1] | out_ready;
    end

    // Each stage resolves its own block from its registered carry-in.
    always_comb begin
        logic [W-1:0]  ai;
        logic [W-1:0]  bi;
        logic [W-1:0]  si;
        logic          ci;
        logic          vi;
        logic [BW-1:0] g;
        logic [BW-1:0] p;
        logic [BW:0]   c;
        logic          t;
        logic          acc;
        int            pk;
        ai   = '0;
        bi   = '0;
        si   = '0;
        ci   = 1'b0;
        vi   = 1'b0;
        g    = '0;
        p    = '0;
        c    = '0;
        t    = 1'b0;
        acc  = 1'b0;
        pk   = 0;
        ov_d = 1'b0;
        for (int k = 0; k < NB; k++) begin
            pk = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                ai = num_one;
                bi = num_two ^ {W{sub}};
                si = '0;
                ci = cin ^ sub;
                vi = in_valid;
            end else begin
                ai = a_q[pk];
                bi = b_q[pk];
                si = s_q[pk];
                ci = c_q[pk];
                vi = v_q[pk];
            end
            g = ai[k*BW +: BW] & bi[k*BW +: BW];
            p = ai[k*BW +: BW] ^ bi[k*BW +: BW];
            c = '0;
            c[0] = ci;
            // Flattened sum-of-products lookahead for every carry.
            for (int i = 0; i < BW; i++) begin
                acc = ci;
                for (int m = 0; m <= i; m++) begin
                    acc = acc & p[m];
                end
                for (int j = 0; j <= i; j++) begin
                    t = g[j];
                    for (int m = j + 1; m <= i; m++) begin
                        t = t & p[m];
                    end
                    acc = acc | t;
                end
                c[i+1] = acc;
            end
            si[k*BW +: BW] = p ^ c[BW-1:0];
            a_d[k] = ai;
            b_d[k] = bi;
            s_d[k] = si;
            c_d[k] = c[BW];
            v_d[k] = vi;
            if (k == NB - 1) begin
                ov_d = c[BW] ^ c[BW-1];
            end
        end
    end

    // Stage registers: shift together when enabled, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NB; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ov_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < NB; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_d[k];
            end
            ov_q <= ov_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = v_q[NB-1];
    assign S         = {c_q[NB-1], s_q[NB-1]};
    assign overflow  = ov_q;

endmodule
